// File: rtl/ccd_timing_pkg.sv
// Shared definitions for the linear CCD timing generator: TCD1500C defaults,
// FSM state encoding, frame-length helper and parameter legality check.
package ccd_timing_pkg;

  localparam int TCD_N_PIX     = 5412;
  localparam int TCD_PIX_DIV   = 40;
  localparam int TCD_RS_W      = 4;
  localparam int TCD_SP_OFS    = 8;
  localparam int TCD_SP_W      = 3;
  localparam int TCD_SAMPLE_PH = 10;
  localparam int TCD_SH_CYC    = 800;
  localparam int TCD_GUARD_CYC = 40;
  localparam int TCD_INTEG_W   = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SH_ON = 3'd1;
  localparam logic [2:0] ST_GUARD = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  function automatic int frame_cyc(input int sh_cyc, input int guard_cyc,
                                   input int n_pix, input int pix_div);
    return sh_cyc + guard_cyc + n_pix * pix_div;
  endfunction

  // The integration counter must reach FRAME_CYC-1 before saturating.
  function automatic bit params_ok(input int n_pix, input int pix_div, input int rs_w,
                                   input int sp_ofs, input int sp_w, input int sample_ph,
                                   input int sh_cyc, input int guard_cyc, input int integ_w);
    longint frame_last;
    frame_last = longint'(frame_cyc(sh_cyc, guard_cyc, n_pix, pix_div)) - 1;
    return n_pix >= 2 && pix_div >= 8 && (pix_div % 2) == 0 &&
           rs_w >= 1 && rs_w <= pix_div / 2 - 1 &&
           sp_w >= 1 && sp_ofs >= 0 && sp_ofs + sp_w <= pix_div &&
           sample_ph >= 0 && sample_ph < pix_div &&
           sh_cyc >= 1 && guard_cyc >= 1 && integ_w >= 1 && integ_w <= 62 &&
           frame_last < (longint'(1) << integ_w);
  endfunction

endpackage

// File: rtl/ccd_pixel_phase.sv
// Pixel-period phase counter and CLK/RS/SP/sample decode; parks at phase 0
// with the CCD clock high whenever the readout is not enabled.
module ccd_pixel_phase #(
  parameter int PIX_DIV   = 40,
  parameter int RS_W      = 4,
  parameter int SP_OFS    = 8,
  parameter int SP_W      = 3,
  parameter int SAMPLE_PH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic ccd_clk,
  output logic rs,
  output logic sp,
  output logic sample,
  output logic wrap
);

  localparam int PH_W = $clog2(PIX_DIV);

  logic [PH_W-1:0] ph;

  assign wrap = en && (ph == PH_W'(PIX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ph <= '0;
    else if (en && !wrap)
      ph <= ph + 1'b1;
    else
      ph <= '0;
  end

  assign ccd_clk = !en || (int'(ph) < PIX_DIV / 2);
  assign rs      = en && (int'(ph) < RS_W);
  assign sp      = en && (int'(ph) >= SP_OFS) && (int'(ph) < SP_OFS + SP_W);
  assign sample  = en && (int'(ph) == SAMPLE_PH);

endmodule

// File: rtl/ccd_linear_timing_gen.sv
// Linear CCD timing generator: trig synchroniser, frame FSM, integration and
// pixel counters; per-pixel waveforms come from ccd_pixel_phase.
module ccd_linear_timing_gen
  import ccd_timing_pkg::*;
#(
  parameter int N_PIX     = TCD_N_PIX,
  parameter int PIX_DIV   = TCD_PIX_DIV,
  parameter int RS_W      = TCD_RS_W,
  parameter int SP_OFS    = TCD_SP_OFS,
  parameter int SP_W      = TCD_SP_W,
  parameter int SAMPLE_PH = TCD_SAMPLE_PH,
  parameter int SH_CYC    = TCD_SH_CYC,
  parameter int GUARD_CYC = TCD_GUARD_CYC,
  parameter int INTEG_W   = TCD_INTEG_W
) (
  input  logic                     CLK20M,
  input  logic                     RST_N,
  input  logic                     trig,
  input  logic                     cont_en,
  input  logic                     stop_req,
  input  logic [INTEG_W-1:0]       integ_cycles,
  output logic                     SH,
  output logic                     CLK,
  output logic                     RS,
  output logic                     SP,
  output logic                     pix_valid,
  output logic [$clog2(N_PIX)-1:0] pix_idx,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     trig_ignored
);

  localparam int PIX_W   = $clog2(N_PIX);
  localparam int CNT_MAX = (SH_CYC > GUARD_CYC) ? SH_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (!params_ok(N_PIX, PIX_DIV, RS_W, SP_OFS, SP_W, SAMPLE_PH,
                 SH_CYC, GUARD_CYC, INTEG_W)) begin : g_bad_params
    $error("ccd_linear_timing_gen: illegal timing parameters");
  end

  logic               trig_s1, trig_s2, trig_d, trig_edge;
  logic [2:0]         state, next_state, end_state;
  logic [CNT_W-1:0]   cnt;
  logic [INTEG_W-1:0] integ_cnt, integ_q, integ_thr;
  logic [PIX_W-1:0]   pix;
  logic               stop_lat, auto_hold;
  logic               ph_wrap, read_last, frame_entry, idle_entry;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge CLK20M or negedge RST_N) begin
    if (!RST_N) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_d    <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      trig_s1   <= trig;
      trig_s2   <= trig_s1;
      trig_d    <= trig_s2;
      trig_edge <= trig_s2 & ~trig_d;
    end
  end

  // integ_cycles of 0 behaves as 1, i.e. a threshold of 0.
  assign integ_thr   = (integ_q == '0) ? '0 : integ_q - 1'b1;
  assign read_last   = (state == ST_READ) && ph_wrap && (pix == PIX_W'(N_PIX - 1));
  assign end_state   = (integ_cnt < integ_thr)       ? ST_WAIT :
                       (stop_lat || !cont_en)        ? ST_IDLE : ST_SH_ON;
  assign frame_entry = (next_state == ST_SH_ON) && (state != ST_SH_ON);
  assign idle_entry  = (next_state == ST_IDLE) && (state != ST_IDLE);

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (trig_edge || (cont_en && !auto_hold)) next_state = ST_SH_ON;
      ST_SH_ON: if (cnt == CNT_W'(SH_CYC - 1))    next_state = ST_GUARD;
      ST_GUARD: if (cnt == CNT_W'(GUARD_CYC - 1)) next_state = ST_READ;
      ST_READ:  if (read_last)                    next_state = end_state;
      ST_WAIT:                                    next_state = end_state;
      default:                                    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK20M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      integ_cnt <= '0;
      integ_q   <= '0;
      pix       <= '0;
      stop_lat  <= 1'b0;
      auto_hold <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state)
        cnt <= '0;
      else if (state == ST_SH_ON || state == ST_GUARD)
        cnt <= cnt + 1'b1;

      if (frame_entry) begin
        integ_cnt <= '0;
        integ_q   <= integ_cycles;
      end else if (integ_cnt != '1) begin
        integ_cnt <= integ_cnt + 1'b1;
      end

      if (state == ST_READ && ph_wrap)
        pix <= read_last ? '0 : pix + 1'b1;

      if (idle_entry)
        stop_lat <= 1'b0;
      else if (state != ST_IDLE && stop_req)
        stop_lat <= 1'b1;

      // After a stop, a held-high cont_en must not relaunch frames; it re-arms
      // once cont_en drops. A trig edge still starts a frame.
      if (!cont_en)
        auto_hold <= 1'b0;
      else if (idle_entry && stop_lat)
        auto_hold <= 1'b1;
    end
  end

  ccd_pixel_phase #(
    .PIX_DIV   (PIX_DIV),
    .RS_W      (RS_W),
    .SP_OFS    (SP_OFS),
    .SP_W      (SP_W),
    .SAMPLE_PH (SAMPLE_PH)
  ) u_phase (
    .clk     (CLK20M),
    .rst_n   (RST_N),
    .en      (state == ST_READ),
    .ccd_clk (CLK),
    .rs      (RS),
    .sp      (SP),
    .sample  (pix_valid),
    .wrap    (ph_wrap)
  );

  assign SH           = (state == ST_SH_ON);
  assign pix_idx      = pix;
  assign frame_start  = (state == ST_SH_ON) && (cnt == '0);
  assign frame_done   = read_last;
  assign busy         = (state != ST_IDLE);
  assign trig_ignored = trig_edge && busy;

endmodule

// File: tb/tb_ccd_linear_timing_gen.sv
// Self-checking bench for ccd_linear_timing_gen with small timing parameters;
// a frame-level reference model predicts every output on every cycle.
module tb_ccd_linear_timing_gen;

  localparam int NP    = 4;
  localparam int PD    = 8;
  localparam int RSW   = 2;
  localparam int SPO   = 4;
  localparam int SPW   = 2;
  localparam int SPH   = 5;
  localparam int SHC   = 4;
  localparam int GC    = 2;
  localparam int FRAME = SHC + GC + NP * PD;

  logic        CLK20M = 1'b0;
  logic        RST_N = 1'b0;
  logic        trig = 1'b0;
  logic        cont_en = 1'b0;
  logic        stop_req = 1'b0;
  logic [31:0] integ_cycles = '0;
  logic        SH, CLK, RS, SP, pix_valid, frame_start, frame_done, busy, trig_ignored;
  logic [1:0]  pix_idx;
  logic [10:0] dut_vec;

  always #25 CLK20M = ~CLK20M;

  ccd_linear_timing_gen #(
    .N_PIX(NP), .PIX_DIV(PD), .RS_W(RSW), .SP_OFS(SPO), .SP_W(SPW),
    .SAMPLE_PH(SPH), .SH_CYC(SHC), .GUARD_CYC(GC), .INTEG_W(32)
  ) dut (
    .CLK20M(CLK20M), .RST_N(RST_N), .trig(trig), .cont_en(cont_en),
    .stop_req(stop_req), .integ_cycles(integ_cycles), .SH(SH), .CLK(CLK),
    .RS(RS), .SP(SP), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .trig_ignored(trig_ignored)
  );

  assign dut_vec = {SH, CLK, RS, SP, pix_valid, frame_start, frame_done,
                    busy, trig_ignored, pix_idx};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position m_t counted from the first SH cycle; the
  // trig edge reaches the frame logic 3 samples after trig is first seen high.
  bit         m_busy, m_hold, m_stop;
  int         m_t, m_P;
  logic [3:0] th;

  task automatic model_step();
    bit ev, was_busy, old_stop, go_idle;
    ev       = th[2] & ~th[3];
    was_busy = m_busy;
    old_stop = m_stop;
    go_idle  = 1'b0;
    if (!m_busy) begin
      if (ev || (cont_en && !m_hold)) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_P    = (integ_cycles == 0) ? 1 : int'(integ_cycles);
      end
    end else if (m_t >= FRAME - 1 && m_t >= m_P - 1) begin
      if (old_stop || !cont_en) begin
        m_busy  = 1'b0;
        go_idle = 1'b1;
      end else begin
        m_t = 0;
        m_P = (integ_cycles == 0) ? 1 : int'(integ_cycles);
      end
    end else begin
      m_t++;
    end
    if (!cont_en) m_hold = 1'b0;
    else if (go_idle && old_stop) m_hold = 1'b1;
    if (go_idle) m_stop = 1'b0;
    else if (was_busy && stop_req) m_stop = 1'b1;
    th = {th[2:0], trig};
  endtask

  initial begin
    m_busy = 0; m_hold = 0; m_stop = 0; m_t = 0; m_P = 1; th = '0;
    forever begin
      @(posedge CLK20M or negedge RST_N);
      if (!RST_N) begin
        m_busy = 0; m_hold = 0; m_stop = 0; m_t = 0; m_P = 1; th = '0;
      end else begin
        model_step();
      end
    end
  end

  function automatic logic [10:0] model_vec();
    logic sh, ck, rs, sp, pv, fs, fd;
    logic [1:0] px;
    int r, ph;
    sh = 0; ck = 1; rs = 0; sp = 0; pv = 0; fs = 0; fd = 0; px = '0;
    if (m_busy) begin
      if (m_t < SHC) begin
        sh = 1;
        fs = (m_t == 0);
      end else if (m_t >= SHC + GC && m_t < FRAME) begin
        r  = m_t - SHC - GC;
        ph = r % PD;
        px = 2'(r / PD);
        ck = (ph < PD / 2);
        rs = (ph < RSW);
        sp = (ph >= SPO) && (ph < SPO + SPW);
        pv = (ph == SPH);
        fd = (m_t == FRAME - 1);
      end
    end
    return {sh, ck, rs, sp, pv, fs, fd, m_busy, m_busy & th[2] & ~th[3], px};
  endfunction

  // Monitor: per-cycle model comparison plus event bookkeeping.
  int cyc = 0;
  int n_pv, n_fd, n_ign, n_sh, n_busy;
  int fs_q[$];
  int idx_q[$];

  always @(posedge CLK20M) cyc <= cyc + 1;

  always @(negedge CLK20M) begin
    check("cycle", 32'(dut_vec), 32'(model_vec()));
    if (frame_start) fs_q.push_back(cyc);
    if (pix_valid) begin
      n_pv++;
      idx_q.push_back(int'(pix_idx));
    end
    if (frame_done)   n_fd++;
    if (trig_ignored) n_ign++;
    if (SH)           n_sh++;
    if (busy)         n_busy++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK20M);
      #5;
    end
  endtask

  task automatic clr();
    n_pv = 0; n_fd = 0; n_ign = 0; n_sh = 0; n_busy = 0;
    fs_q.delete();
    idx_q.delete();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick(2);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick(1);
    check("idle_reached", 32'(busy), 0);
  endtask

  task automatic check_periods(input string tag, input int first, input int period);
    for (int i = first + 1; i < fs_q.size(); i++)
      check(tag, 32'(fs_q[i] - fs_q[i-1]), 32'(period));
  endtask

  int c0, p0;

  initial begin
    n_pv = 0; n_fd = 0; n_ign = 0; n_sh = 0; n_busy = 0;
    tick(3);
    RST_N = 1'b1;
    tick(2);

    // Idle with cont_en low: nothing moves.
    clr();
    tick(20);
    check("idle_busy", 32'(n_busy), 0);
    check("idle_sh", 32'(n_sh), 0);

    // Single-shot frame, integ 0.
    clr();
    c0 = cyc;
    pulse_trig();
    tick(60);
    check("single_frames", 32'(fs_q.size()), 1);
    if (fs_q.size() > 0) check("start_latency", 32'(fs_q[0] - c0), 4);
    check("single_sh_cycles", 32'(n_sh), SHC);
    check("single_pv", 32'(n_pv), NP);
    for (int i = 0; i < idx_q.size(); i++) check("single_pix_idx", 32'(idx_q[i]), 32'(i));
    check("single_done", 32'(n_fd), 1);
    check("single_idle", 32'(busy), 0);

    // Continuous: integ 100 sets the period, integ 10 falls back to FRAME_CYC.
    clr();
    integ_cycles = 100;
    cont_en = 1'b1;
    tick(420);
    check("cont100_frames", 32'(fs_q.size() >= 4), 1);
    check_periods("period_100", 0, 100);
    integ_cycles = 10;
    tick(110);
    clr();
    tick(200);
    check("cont38_frames", 32'(fs_q.size() >= 5), 1);
    check_periods("period_38", 0, FRAME);
    cont_en = 1'b0;
    wait_idle(200);

    // stop_req during READ of frame 2 with cont_en held high.
    clr();
    integ_cycles = 0;
    cont_en = 1'b1;
    for (int i = 0; i < 200 && fs_q.size() < 2; i++) tick(1);
    check("stop_second_frame", 32'(fs_q.size()), 2);
    p0 = n_pv;
    tick(SHC + GC + 6);
    stop_req = 1'b1;
    tick(1);
    stop_req = 1'b0;
    tick(120);
    check("stop_pv_frame2", 32'(n_pv - p0), NP);
    check("stop_no_third", 32'(fs_q.size()), 2);
    check("stop_idle", 32'(busy), 0);
    cont_en = 1'b0;
    tick(5);

    // trig edge during READ is reported and otherwise ignored.
    clr();
    pulse_trig();
    tick(4 + SHC + GC + 8);
    pulse_trig();
    tick(60);
    check("ign_count", 32'(n_ign), 1);
    check("ign_frames", 32'(fs_q.size()), 1);
    check("ign_pv", 32'(n_pv), NP);
    check("ign_done", 32'(n_fd), 1);

    // Reset mid-READ, then a clean frame after release.
    pulse_trig();
    tick(12);
    RST_N = 1'b0;
    #1;
    check("rst_outputs", 32'(dut_vec), 32'(11'b010_0000_0000));
    tick(3);
    RST_N = 1'b1;
    tick(3);
    clr();
    c0 = cyc;
    pulse_trig();
    tick(60);
    check("post_rst_frames", 32'(fs_q.size()), 1);
    if (fs_q.size() > 0) check("post_rst_latency", 32'(fs_q[0] - c0), 4);
    check("post_rst_pv", 32'(n_pv), NP);

    // Randomised mix of all inputs, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) cont_en = ~cont_en;
      trig     = ($urandom_range(0, 39) == 0) || (trig && ($urandom_range(0, 1) == 1));
      stop_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) integ_cycles = $urandom_range(0, 90);
      tick(1);
    end
    trig = 1'b0;
    stop_req = 1'b0;
    cont_en = 1'b0;
    wait_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
